// File: rtl/audio_stream_pkg.sv
// Shared types and constants for the stereo playback sequencer: state encoding,
// byte-slot positions inside a 32-bit frame and the frame-assembly helper.
package audio_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREFILL  = 2'd1,
        ST_PLAY     = 2'd2,
        ST_UNDERRUN = 2'd3
    } state_e;

    localparam int FRAME_BYTES = 4;

    // Wire order is L-low, L-high, R-low, R-high; frame layout is {L, R}.
    localparam int BYTE0_LSB = 16;
    localparam int BYTE1_LSB = 24;
    localparam int BYTE2_LSB = 0;
    localparam int BYTE3_LSB = 8;

    function automatic logic [31:0] insert_byte(input logic [31:0] frame,
                                                input logic [1:0]  idx,
                                                input logic [7:0]  data);
        logic [31:0] f;
        f = frame;
        case (idx)
            2'd0:    f[BYTE0_LSB +: 8] = data;
            2'd1:    f[BYTE1_LSB +: 8] = data;
            2'd2:    f[BYTE2_LSB +: 8] = data;
            2'd3:    f[BYTE3_LSB +: 8] = data;
            default: f = frame;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/audio_stream_ctrl_if.sv
// Bus bundle between the playback sequencer and its neighbours (uart_rx, fifo,
// DACs). master = sequencer side, slave = surrounding path / bench side.
interface audio_stream_ctrl_if #(
    parameter int FILL_BITS = 13
);
    logic [7:0]           rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic [FILL_BITS-1:0] fifo_fill;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 fifo_wr_en;
    logic [31:0]          fifo_wr_data;
    logic                 fifo_rd_en;
    logic                 dac_reset;
    logic [1:0]           state;
    logic                 overflow;
    logic                 underrun;

    modport master (
        input  rx_data, rx_valid, fifo_fill, fifo_empty, fifo_full,
        output rx_ready, fifo_wr_en, fifo_wr_data, fifo_rd_en,
               dac_reset, state, overflow, underrun
    );

    modport slave (
        output rx_data, rx_valid, fifo_fill, fifo_empty, fifo_full,
        input  rx_ready, fifo_wr_en, fifo_wr_data, fifo_rd_en,
               dac_reset, state, overflow, underrun
    );
endinterface

// File: rtl/sample_tick_gen.sv
// Free-running sample-rate divider: one-cycle tick whenever the counter wraps
// to 0. Never paused; the sequencer decides whether a tick matters.
module sample_tick_gen #(
    parameter int CLK_FREQ    = 12_000_000,
    parameter int SAMPLE_FREQ = 44_100
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);
    localparam int DIV = CLK_FREQ / SAMPLE_FREQ;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    // Next count and wrap detection.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (cnt_q == CW'(DIV - 1)) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end else begin
            cnt_d  = cnt_q + CW'(1);
            tick_d = 1'b0;
        end
    end

    // Counter and tick registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;
endmodule

// File: rtl/audio_stream_ctrl.sv
// UART-to-FIFO-to-DAC playback sequencer: frame assembly with resync, paced
// FIFO reads, DAC reset and hysteretic CTS. Optional UNDERRUN_COUNT_EN macro
// adds a saturating underrun_count output.
module audio_stream_ctrl
    import audio_stream_pkg::*;
#(
    parameter int CLK_FREQ      = 12_000_000,
    parameter int SAMPLE_FREQ   = 44_100,
    parameter int FIFO_SIZE     = 4096,
    parameter int FILL_BITS     = $clog2(FIFO_SIZE) + 1,
    parameter int PREFILL_LEVEL = 2048,
    parameter int LOW_MARK      = 1228,
    parameter int HIGH_MARK     = 2048,
    parameter int RESYNC_CYCLES = 1200
) (
    input  logic                   clk,
    input  logic                   reset_n,
`ifdef UNDERRUN_COUNT_EN
    output logic [15:0]            underrun_count,
`endif
    audio_stream_ctrl_if.master    bus
);
    localparam int         RS_W     = $clog2(RESYNC_CYCLES + 1);
    localparam logic [1:0] LAST_IDX = 2'(FRAME_BYTES - 1);

    state_e            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [31:0]       frame_q, frame_d;
    logic [RS_W-1:0]   rs_cnt_q, rs_cnt_d;
    logic              wr_en_q, wr_en_d;
    logic              overflow_q, overflow_d;
    logic              rd_en_q, rd_en_d;
    logic              underrun_q, underrun_d;
    logic              dac_reset_q, dac_reset_d;
    logic              rx_ready_q, rx_ready_d;
    logic              tick;

    sample_tick_gen #(
        .CLK_FREQ    (CLK_FREQ),
        .SAMPLE_FREQ (SAMPLE_FREQ)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick)
    );

    // Frame assembly, overflow drop and partial-frame resync timeout.
    always_comb begin
        idx_d      = idx_q;
        frame_d    = frame_q;
        rs_cnt_d   = rs_cnt_q;
        wr_en_d    = 1'b0;
        overflow_d = overflow_q;
        if (bus.rx_valid) begin
            frame_d  = insert_byte(frame_q, idx_q, bus.rx_data);
            rs_cnt_d = '0;
            if (idx_q == LAST_IDX) begin
                idx_d = 2'd0;
                if (bus.fifo_full) begin
                    overflow_d = 1'b1;
                end else begin
                    wr_en_d = 1'b1;
                end
            end else begin
                idx_d = idx_q + 2'd1;
            end
        end else if (idx_q != 2'd0) begin
            if (rs_cnt_q == RS_W'(RESYNC_CYCLES - 1)) begin
                idx_d    = 2'd0;
                rs_cnt_d = '0;
            end else begin
                rs_cnt_d = rs_cnt_q + RS_W'(1);
            end
        end else begin
            rs_cnt_d = '0;
        end
    end

    // Playback state machine; reads and underrun detection only act in PLAY.
    always_comb begin
        state_d    = state_q;
        rd_en_d    = 1'b0;
        underrun_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wr_en_q) state_d = ST_PREFILL;
                else         state_d = ST_IDLE;
            end
            ST_PREFILL: begin
                if (bus.fifo_fill >= FILL_BITS'(PREFILL_LEVEL)) state_d = ST_PLAY;
                else                                             state_d = ST_PREFILL;
            end
            ST_PLAY: begin
                if (tick && bus.fifo_empty) begin
                    state_d    = ST_UNDERRUN;
                    underrun_d = 1'b1;
                end else if (tick) begin
                    rd_en_d = 1'b1;
                end else begin
                    state_d = ST_PLAY;
                end
            end
            ST_UNDERRUN: begin
                if (wr_en_q) state_d = ST_PREFILL;
                else         state_d = ST_UNDERRUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // DAC reset follows the registered state; CTS uses hysteresis between marks.
    always_comb begin
        dac_reset_d = (state_q != ST_PLAY);
        rx_ready_d  = rx_ready_q;
        if (bus.fifo_fill >= FILL_BITS'(HIGH_MARK)) begin
            rx_ready_d = 1'b0;
        end else if (bus.fifo_fill <= FILL_BITS'(LOW_MARK)) begin
            rx_ready_d = 1'b1;
        end else begin
            rx_ready_d = rx_ready_q;
        end
    end

    // Sequencer state and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= 2'd0;
            frame_q     <= 32'd0;
            rs_cnt_q    <= '0;
            wr_en_q     <= 1'b0;
            overflow_q  <= 1'b0;
            rd_en_q     <= 1'b0;
            underrun_q  <= 1'b0;
            dac_reset_q <= 1'b1;
            rx_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            frame_q     <= frame_d;
            rs_cnt_q    <= rs_cnt_d;
            wr_en_q     <= wr_en_d;
            overflow_q  <= overflow_d;
            rd_en_q     <= rd_en_d;
            underrun_q  <= underrun_d;
            dac_reset_q <= dac_reset_d;
            rx_ready_q  <= rx_ready_d;
        end
    end

`ifdef UNDERRUN_COUNT_EN
    logic [15:0] ucnt_q, ucnt_d;

    // Saturating count of UNDERRUN entries.
    always_comb begin
        if (underrun_d && (ucnt_q != 16'hFFFF)) ucnt_d = ucnt_q + 16'd1;
        else                                    ucnt_d = ucnt_q;
    end

    // Underrun counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ucnt_q <= 16'd0;
        else          ucnt_q <= ucnt_d;
    end

    assign underrun_count = ucnt_q;
`endif

    assign bus.fifo_wr_en   = wr_en_q;
    assign bus.fifo_wr_data = frame_q;
    assign bus.fifo_rd_en   = rd_en_q;
    assign bus.dac_reset    = dac_reset_q;
    assign bus.rx_ready     = rx_ready_q;
    assign bus.state        = state_q;
    assign bus.overflow     = overflow_q;
    assign bus.underrun     = underrun_q;
endmodule

// File: tb/tb_audio_stream_ctrl.sv
// Directed bench for audio_stream_ctrl: written frames are checked against a
// scoreboard queue, read pacing and state outputs against bench constants.
module tb_audio_stream_ctrl;
    localparam int FILL_BITS = 13;
    localparam int TICK_DIV  = 272;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    audio_stream_ctrl_if #(.FILL_BITS(FILL_BITS)) bus ();

`ifdef UNDERRUN_COUNT_EN
    logic [15:0] underrun_count;
`endif

    audio_stream_ctrl dut (
        .clk            (clk),
        .reset_n        (reset_n),
`ifdef UNDERRUN_COUNT_EN
        .underrun_count (underrun_count),
`endif
        .bus            (bus)
    );

    int          errors = 0;
    int          checks = 0;
    logic [31:0] sb[$];
    int          wr_count = 0;
    int          rd_count = 0;
    int          cyc = 0;
    int          last_rd = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on writes, checks read pacing.
    always @(negedge clk) begin
        logic [31:0] exp;
        cyc++;
        if (bus.fifo_wr_en === 1'b1) begin
            wr_count++;
            check("wr_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                check("wr_data", bus.fifo_wr_data, exp);
            end
        end
        if (bus.fifo_rd_en === 1'b1) begin
            rd_count++;
            check("rd_in_play", 32'(bus.state), 32'd2);
            if (last_rd >= 0) check("rd_period", 32'(cyc - last_rd), 32'(TICK_DIV));
            last_rd = cyc;
        end
        if (bus.state !== 2'd2) last_rd = -1;
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        send_byte(b3);
    endtask

    task automatic set_fill(input int f);
        @(negedge clk);
        bus.fifo_fill = FILL_BITS'(f);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int saved;
        bit found;
        bus.rx_data    = 8'd0;
        bus.rx_valid   = 1'b0;
        bus.fifo_fill  = '0;
        bus.fifo_empty = 1'b1;
        bus.fifo_full  = 1'b0;

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_wr_en", 32'(bus.fifo_wr_en), 32'd0);
        check("rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        check("rst_dac_reset", 32'(bus.dac_reset), 32'd1);
        check("rst_rx_ready", 32'(bus.rx_ready), 32'd1);
        check("rst_state", 32'(bus.state), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        check("rst_underrun", 32'(bus.underrun), 32'd0);
`ifdef UNDERRUN_COUNT_EN
        check("rst_ucount", 32'(underrun_count), 32'd0);
`endif
        reset_n = 1'b1;

        // First frame: IDLE -> PREFILL.
        sb.push_back(32'h1234_5678);
        send_frame(8'h34, 8'h12, 8'h78, 8'h56);
        repeat (2) @(negedge clk);
        check("first_wr_count", 32'(wr_count), 32'd1);
        check("prefill_state", 32'(bus.state), 32'd1);
        check("prefill_dac", 32'(bus.dac_reset), 32'd1);

        // Reach prefill level -> PLAY, reads paced at the sample rate.
        bus.fifo_empty = 1'b0;
        set_fill(2048);
        check("play_state", 32'(bus.state), 32'd2);
        check("play_dac", 32'(bus.dac_reset), 32'd0);
        found = 1'b0;
        for (int i = 0; i < 1500 && !found; i++) begin
            @(negedge clk);
            if (rd_count >= 4) found = 1'b1;
        end
        check("rd_pulses_seen", 32'(found), 32'd1);

        // Flow-control hysteresis.
        set_fill(0);
        check("cts_fill0", 32'(bus.rx_ready), 32'd1);
        set_fill(2047);
        check("cts_fill2047", 32'(bus.rx_ready), 32'd1);
        set_fill(2048);
        check("cts_fill2048", 32'(bus.rx_ready), 32'd0);
        set_fill(1500);
        check("cts_fill1500", 32'(bus.rx_ready), 32'd0);
        set_fill(1229);
        check("cts_fill1229", 32'(bus.rx_ready), 32'd0);
        set_fill(1228);
        check("cts_fill1228", 32'(bus.rx_ready), 32'd1);

        // Underrun: empty FIFO at a tick in PLAY.
        @(negedge clk);
        bus.fifo_empty = 1'b1;
        @(negedge clk);
        saved = rd_count;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (bus.underrun === 1'b1) found = 1'b1;
        end
        check("underrun_seen", 32'(found), 32'd1);
        check("underrun_state", 32'(bus.state), 32'd3);
        check("underrun_no_read", 32'(rd_count), 32'(saved));
`ifdef UNDERRUN_COUNT_EN
        check("underrun_count", 32'(underrun_count), 32'd1);
`endif
        @(negedge clk);
        check("underrun_pulse_len", 32'(bus.underrun), 32'd0);
        check("underrun_dac", 32'(bus.dac_reset), 32'd1);
        bus.fifo_fill = FILL_BITS'(100);
        sb.push_back(32'h0201_0403);
        send_frame(8'h01, 8'h02, 8'h03, 8'h04);
        repeat (2) @(negedge clk);
        check("recover_state", 32'(bus.state), 32'd1);

        // Resync: partial frame discarded after exactly the idle timeout.
        saved = wr_count;
        send_byte(8'h11);
        send_byte(8'h22);
        repeat (1200) @(negedge clk);
        sb.push_back(32'hBBAA_DDCC);
        send_frame(8'hAA, 8'hBB, 8'hCC, 8'hDD);
        repeat (3) @(negedge clk);
        check("resync_one_write", 32'(wr_count - saved), 32'd1);

        // Overflow: full FIFO on the last byte drops the frame, flag is sticky.
        saved = wr_count;
        bus.fifo_full = 1'b1;
        send_frame(8'h5A, 8'h5B, 8'h5C, 8'h5D);
        repeat (2) @(negedge clk);
        bus.fifo_full = 1'b0;
        check("ovf_no_write", 32'(wr_count), 32'(saved));
        check("ovf_set", 32'(bus.overflow), 32'd1);
        sb.push_back(32'h6655_8877);
        send_frame(8'h55, 8'h66, 8'h77, 8'h88);
        repeat (2) @(negedge clk);
        check("ovf_sticky", 32'(bus.overflow), 32'd1);

        // Async reset mid-frame while playing.
        bus.fifo_empty = 1'b0;
        set_fill(2048);
        check("pre_rst_state", 32'(bus.state), 32'd2);
        send_byte(8'hE1);
        send_byte(8'hE2);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_state", 32'(bus.state), 32'd0);
        check("async_rst_ovf", 32'(bus.overflow), 32'd0);
        check("async_rst_dac", 32'(bus.dac_reset), 32'd1);
        check("async_rst_cts", 32'(bus.rx_ready), 32'd1);
        bus.fifo_fill  = '0;
        bus.fifo_empty = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        sb.push_back(32'hC2C1_C4C3);
        send_frame(8'hC1, 8'hC2, 8'hC3, 8'hC4);
        repeat (3) @(negedge clk);
        check("post_rst_state", 32'(bus.state), 32'd1);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
